pipe_latch_chain: RTL and testbench

//  Parametrised inter-stage pipeline latch that generalises the fixed-field EX/MEM-style registers.

---
 rtl/pipe_latch_chain_pkg.sv | 24 ++
 rtl/pipe_latch_chain_if.sv | 45 ++++
 rtl/pipe_latch_chain_slot.sv | 54 +++++
 rtl/pipe_latch_chain.sv | 156 +++++++++++++++
 tb/tb_pipe_latch_chain.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/pipe_latch_chain_pkg.sv
// Shared types for the parametrised pipeline latch chain: per-cycle command and per-slot select.
// Optional statistics are enabled with PIPE_LATCH_STATS_EN (see pipe_latch_chain).
`default_nettype none

package pipe_latch_chain_pkg;

  localparam int PIPE_MAX_DEPTH = 4;

  typedef enum logic [1:0] {
    PCMD_HOLD,
    PCMD_ADVANCE,
    PCMD_FLUSH,
    PCMD_FREEZE
  } pipe_cmd_t;

  typedef enum logic [1:0] {
    SLOT_HOLD,
    SLOT_LOAD,
    SLOT_BUBBLE
  } slot_op_t;

endpackage

`default_nettype wire

// File: rtl/pipe_latch_chain_if.sv
// Stage-to-stage bundle for pipe_latch_chain; stats outputs exist only with PIPE_LATCH_STATS_EN.
// master = the surrounding pipeline, slave = the latch chain.
`default_nettype none

interface pipe_latch_chain_if #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 1
);

  localparam int OCC_W = $clog2(DEPTH + 1);

  logic             ihit;
  logic             dhit;
  logic             stall;
  logic             flush;
  logic             valid_in;
  logic [WIDTH-1:0] data_in;
  logic             valid_out;
  logic [WIDTH-1:0] data_out;
  logic             halt_out;
  logic [OCC_W-1:0] occupancy;
`ifdef PIPE_LATCH_STATS_EN
  logic [31:0]      stall_cycles;
  logic [31:0]      bubble_count;
`endif

  modport master (
    output ihit, dhit, stall, flush, valid_in, data_in,
`ifdef PIPE_LATCH_STATS_EN
    input  stall_cycles, bubble_count,
`endif
    input  valid_out, data_out, halt_out, occupancy
  );

  modport slave (
    input  ihit, dhit, stall, flush, valid_in, data_in,
`ifdef PIPE_LATCH_STATS_EN
    output stall_cycles, bubble_count,
`endif
    output valid_out, data_out, halt_out, occupancy
  );

endinterface

`default_nettype wire

// File: rtl/pipe_latch_chain_slot.sv
// pipe_slot: one payload+valid register with hold / load / bubble select.
// A bubble keeps the non-control bits of its source for debug visibility.
`default_nettype none

module pipe_slot
  import pipe_latch_chain_pkg::*;
#(
  parameter int               WIDTH     = 64,
  parameter logic [WIDTH-1:0] CTRL_MASK = '0
) (
  input  wire logic             clk_i,
  input  wire logic             rst_i,
  input  wire slot_op_t         op_i,
  input  wire logic [WIDTH-1:0] data_i,
  input  wire logic             valid_i,
  output logic      [WIDTH-1:0] data_o,
  output logic                  valid_o
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    case (op_i)
      SLOT_LOAD: begin
        data_d  = data_i;
        valid_d = valid_i;
      end
      SLOT_BUBBLE: begin
        data_d  = data_i & ~CTRL_MASK;
        valid_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule

`default_nettype wire

// File: rtl/pipe_latch_chain.sv
// pipe_latch_chain: DEPTH-slot inter-stage latch with stall hold, flush bubbles and sticky halt freeze.
// Define PIPE_LATCH_STATS_EN to add saturating stall_cycles / bubble_count outputs.
`default_nettype none

module pipe_latch_chain
  import pipe_latch_chain_pkg::*;
#(
  parameter int               WIDTH     = 64,
  parameter int               DEPTH     = 1,
  parameter logic [WIDTH-1:0] CTRL_MASK = '0,
  parameter int               HALT_BIT  = 0
) (
  input  wire logic    CLK,
  input  wire logic    RST,
  pipe_latch_chain_if.slave bus
);

  localparam int OCC_W = $clog2(DEPTH + 1);

  if (DEPTH < 1 || DEPTH > PIPE_MAX_DEPTH) begin : g_chk_depth
    $error("pipe_latch_chain: DEPTH must be 1..%0d", PIPE_MAX_DEPTH);
  end
  if (HALT_BIT >= WIDTH) begin : g_chk_halt_bit
    $error("pipe_latch_chain: HALT_BIT must be < WIDTH");
  end else if (CTRL_MASK[HALT_BIT] != 1'b1) begin : g_chk_halt_mask
    $error("pipe_latch_chain: HALT_BIT must be a control bit in CTRL_MASK");
  end

  logic [WIDTH-1:0] slot_data [DEPTH];
  logic             slot_valid[DEPTH];
  slot_op_t         slot_op   [DEPTH];
  logic [WIDTH-1:0] slot_din  [DEPTH];
  logic             slot_vin  [DEPTH];

  logic      frozen_q, frozen_d;
  logic      hit, advance, halt_now, shift;
  pipe_cmd_t cmd;

  assign hit      = bus.ihit | bus.dhit;
  assign advance  = hit & ~bus.stall & ~frozen_q;
  // A valid halt sitting at the output freezes on this very edge, even against a flush.
  assign halt_now = slot_valid[DEPTH-1] & slot_data[DEPTH-1][HALT_BIT];
  assign frozen_d = frozen_q | halt_now;

  always_comb begin
    cmd = PCMD_HOLD;
    if (frozen_q || halt_now) begin
      cmd = PCMD_FREEZE;
    end else if (bus.flush) begin
      cmd = PCMD_FLUSH;
    end else if (advance) begin
      cmd = PCMD_ADVANCE;
    end
  end

  assign shift = (cmd == PCMD_ADVANCE) || ((cmd == PCMD_FLUSH) && advance);

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      slot_op[i]  = SLOT_HOLD;
      slot_din[i] = '0;
      slot_vin[i] = 1'b0;
    end
    case (cmd)
      PCMD_FLUSH: begin
        slot_op[0]  = SLOT_BUBBLE;
        slot_din[0] = advance ? bus.data_in : slot_data[0];
      end
      PCMD_ADVANCE: begin
        slot_op[0]  = bus.valid_in ? SLOT_LOAD : SLOT_BUBBLE;
        slot_din[0] = bus.data_in;
        slot_vin[0] = bus.valid_in;
      end
      default: ;
    endcase
    if (shift) begin
      for (int i = 1; i < DEPTH; i++) begin
        slot_op[i]  = SLOT_LOAD;
        slot_din[i] = slot_data[i-1];
        slot_vin[i] = slot_valid[i-1];
      end
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    pipe_slot #(
      .WIDTH    (WIDTH),
      .CTRL_MASK(CTRL_MASK)
    ) u_slot (
      .clk_i  (CLK),
      .rst_i  (RST),
      .op_i   (slot_op[g]),
      .data_i (slot_din[g]),
      .valid_i(slot_vin[g]),
      .data_o (slot_data[g]),
      .valid_o(slot_valid[g])
    );
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      frozen_q <= 1'b0;
    end else begin
      frozen_q <= frozen_d;
    end
  end

  logic [OCC_W-1:0] occ;
  always_comb begin
    occ = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occ = occ + OCC_W'(slot_valid[i]);
    end
  end

  assign bus.valid_out = slot_valid[DEPTH-1];
  assign bus.data_out  = slot_data[DEPTH-1];
  assign bus.halt_out  = frozen_q;
  assign bus.occupancy = occ;

`ifdef PIPE_LATCH_STATS_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] bubble_count_q, bubble_count_d;
  logic        stall_evt, bubble_evt;

  assign stall_evt  = hit & bus.stall & ~frozen_q;
  assign bubble_evt = (slot_op[0] == SLOT_BUBBLE);

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    bubble_count_d = bubble_count_q;
    if (stall_evt && (stall_cycles_q != 32'hFFFF_FFFF)) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end
    if (bubble_evt && (bubble_count_q != 32'hFFFF_FFFF)) begin
      bubble_count_d = bubble_count_q + 32'd1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stall_cycles_q <= '0;
      bubble_count_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      bubble_count_q <= bubble_count_d;
    end
  end

  assign bus.stall_cycles = stall_cycles_q;
  assign bus.bubble_count = bubble_count_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_latch_chain.sv
// Self-checking bench for pipe_latch_chain (WIDTH=64, DEPTH=2): directed scenarios then random traffic
// against a slot-array reference model. Stats are checked when PIPE_LATCH_STATS_EN is defined.
`default_nettype none

module tb_pipe_latch_chain;

  localparam int          W    = 64;
  localparam int          D    = 2;
  localparam logic [63:0] MASK = 64'hFF00_0000_0000_0000;
  localparam int          HB   = 56;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  pipe_latch_chain_if #(.WIDTH(W), .DEPTH(D)) bus ();

  pipe_latch_chain #(
    .WIDTH    (W),
    .DEPTH    (D),
    .CTRL_MASK(MASK),
    .HALT_BIT (HB)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  int n_total = 0;
  int n_pass  = 0;

  logic [63:0] m_data [D];
  logic        m_valid[D];
  logic        m_frozen;
  logic [31:0] m_stall;
  logic [31:0] m_bub;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic check_model(input string tag);
    int occ = 0;
    for (int i = 0; i < D; i++) occ += int'(m_valid[i]);
    chk({tag, ".valid_out"}, 64'(bus.valid_out), 64'(m_valid[D-1]));
    chk({tag, ".data_out"},  bus.data_out,       m_data[D-1]);
    chk({tag, ".halt_out"},  64'(bus.halt_out),  64'(m_frozen));
    chk({tag, ".occupancy"}, 64'(bus.occupancy), 64'(occ));
`ifdef PIPE_LATCH_STATS_EN
    chk({tag, ".stall_cycles"}, 64'(bus.stall_cycles), 64'(m_stall));
    chk({tag, ".bubble_count"}, 64'(bus.bubble_count), 64'(m_bub));
`endif
  endtask

  task automatic drive(input logic ih, input logic dh, input logic st, input logic fl,
                       input logic vi, input logic [63:0] di);
    bus.ihit = ih; bus.dhit = dh; bus.stall = st; bus.flush = fl;
    bus.valid_in = vi; bus.data_in = di;
  endtask

  // Reference: one edge of the spec's priority list applied to the model slots.
  task automatic step(input string tag);
    logic hit, adv, halt_at_out, bubble;
    hit         = bus.ihit | bus.dhit;
    adv         = hit && !bus.stall && !m_frozen;
    halt_at_out = m_valid[D-1] && m_data[D-1][HB];
    bubble      = 1'b0;
    if (hit && bus.stall && !m_frozen && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
    if (m_frozen || halt_at_out) begin
      m_frozen = 1'b1;
    end else if (bus.flush) begin
      bubble = 1'b1;
      if (adv) begin
        for (int i = D - 1; i > 0; i--) begin m_data[i] = m_data[i-1]; m_valid[i] = m_valid[i-1]; end
        m_data[0] = bus.data_in & ~MASK;
      end else begin
        m_data[0] = m_data[0] & ~MASK;
      end
      m_valid[0] = 1'b0;
    end else if (adv) begin
      for (int i = D - 1; i > 0; i--) begin m_data[i] = m_data[i-1]; m_valid[i] = m_valid[i-1]; end
      m_data[0]  = bus.valid_in ? bus.data_in : (bus.data_in & ~MASK);
      m_valid[0] = bus.valid_in;
      bubble     = !bus.valid_in;
    end
    if (bubble && m_bub != 32'hFFFF_FFFF) m_bub = m_bub + 1;
    @(posedge CLK);
    #1;
    check_model(tag);
  endtask

  // Asserted between edges: outputs must clear without a clock.
  task automatic apply_reset(input string tag);
    RST = 1'b1;
    #1;
    for (int i = 0; i < D; i++) begin m_data[i] = '0; m_valid[i] = 1'b0; end
    m_frozen = 1'b0; m_stall = '0; m_bub = '0;
    chk({tag, ".valid_out"}, 64'(bus.valid_out), 64'd0);
    chk({tag, ".data_out"},  bus.data_out,       64'd0);
    chk({tag, ".halt_out"},  64'(bus.halt_out),  64'd0);
    check_model(tag);
    #1;
    RST = 1'b0;
  endtask

  initial begin
    logic [63:0] d;
    drive(0, 0, 0, 0, 0, '0);
    #1;
    apply_reset("reset");

    // 1: pass-through latency of two advancing edges
    drive(1, 0, 0, 0, 1, 64'h0000_0000_1234_5678);
    step("t1.e1");
    chk("t1.e1_valid", 64'(bus.valid_out), 64'd0);
    step("t1.e2");
    chk("t1.e2_data",  bus.data_out, 64'h0000_0000_1234_5678);
    chk("t1.e2_valid", 64'(bus.valid_out), 64'd1);
    chk("t1.e2_occ",   64'(bus.occupancy), 64'd2);

    // 2: stall holds a full pipe
    drive(1, 0, 1, 0, 1, 64'h0000_0000_DEAD_BEEF);
    for (int k = 0; k < 3; k++) step("t2.stall");
    chk("t2.data", bus.data_out, 64'h0000_0000_1234_5678);
    chk("t2.occ",  64'(bus.occupancy), 64'd2);
`ifdef PIPE_LATCH_STATS_EN
    chk("t2.stall_cycles", 64'(bus.stall_cycles), 64'd3);
`endif

    // 3: in-place flush with no hit clears control bits of slot 0 only
    drive(1, 0, 0, 0, 1, 64'hFF00_0000_0000_00AA);
    step("t3.load");
    drive(0, 0, 0, 1, 1, 64'h0000_0000_0000_5555);
    step("t3.flush");
    chk("t3.slot1_kept", bus.data_out, 64'h0000_0000_1234_5678);
    drive(1, 0, 0, 0, 1, 64'h0000_0000_0000_0001);
    step("t3.shift");
    chk("t3.bubble_data",  bus.data_out, 64'h0000_0000_0000_00AA);
    chk("t3.bubble_valid", 64'(bus.valid_out), 64'd0);

    // 5: no hit holds; a lone dhit shifts
    drive(0, 0, 0, 0, 1, 64'h0000_0000_0000_0077);
    for (int k = 0; k < 5; k++) step("t5.idle");
    chk("t5.idle_data", bus.data_out, 64'h0000_0000_0000_00AA);
    drive(0, 1, 0, 0, 1, 64'h0000_0000_0000_0077);
    step("t5.dhit");
    chk("t5.dhit_data",  bus.data_out, 64'h0000_0000_0000_0001);
    chk("t5.dhit_valid", 64'(bus.valid_out), 64'd1);

    // 4: halt reaches output, then the chain freezes
    drive(1, 0, 0, 0, 1, 64'h0100_0000_0000_0042);
    step("t4.push");
    drive(1, 0, 0, 0, 1, 64'h0000_0000_0000_0099);
    step("t4.out");
    chk("t4.at_out", bus.data_out, 64'h0100_0000_0000_0042);
    chk("t4.not_yet", 64'(bus.halt_out), 64'd0);
    drive(1, 0, 0, 1, 1, 64'h0000_0000_0000_1111);
    step("t4.freeze");
    chk("t4.halt_out", 64'(bus.halt_out), 64'd1);
    for (int k = 0; k < 4; k++) begin
      drive(1'($urandom), 1'($urandom), 1'b0, 1'($urandom), 1'b1, {$urandom, $urandom});
      step("t4.frozen");
    end
    chk("t4.frozen_data", bus.data_out, 64'h0100_0000_0000_0042);

    // 6: async reset in the middle of a cycle
    apply_reset("t6.clear");
    drive(1, 0, 0, 0, 1, 64'h0000_0000_0000_0123);
    step("t6.fill1");
    step("t6.fill2");
    apply_reset("t6.async");

    // Random traffic; halts are rare so the chain keeps moving, resets release freezes.
    for (int n = 0; n < 400; n++) begin
      d = {$urandom, $urandom};
      d[HB] = ($urandom_range(0, 29) == 0);
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 5) == 0),
            1'($urandom_range(0, 3) != 0), d);
      step("rand");
      if ((n % 60) == 59) apply_reset("rand.rst");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
